// File: rtl/hamming_pkg.sv
// hamming_pkg: shared types and constants for the Hamming(8,4) byte decoder.
//   - pair_state_t : nibble pairing FSM states
//   - CW_*         : codeword bit positions (bit i = Hamming position i+1)
//   - dec_class_t  : decode classification of a single codeword
//   - DEFAULT_CNT_W: default width of the saturating error counters
//   - parity7      : even-parity helper over the seven Hamming bits
package hamming_pkg;

  typedef enum logic {
    WAIT_HI = 1'b0,
    WAIT_LO = 1'b1
  } pair_state_t;

  localparam int unsigned CW_P1 = 0;
  localparam int unsigned CW_P2 = 1;
  localparam int unsigned CW_D0 = 2;
  localparam int unsigned CW_P4 = 3;
  localparam int unsigned CW_D1 = 4;
  localparam int unsigned CW_D2 = 5;
  localparam int unsigned CW_D3 = 6;
  localparam int unsigned CW_P8 = 7;

  typedef enum logic [1:0] {
    CLASS_CLEAN  = 2'd0,
    CLASS_CORR   = 2'd1,
    CLASS_UNCORR = 2'd2
  } dec_class_t;

  localparam int unsigned DEFAULT_CNT_W = 16;

  function automatic logic parity7(input logic [6:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/hamming84_decode.sv
// hamming84_decode: combinational extended Hamming(8,4) SECDED decode.
// Ports:
//   codeword  in  8 : received codeword
//   nibble    out 4 : data nibble {d3,d2,d1,d0}, corrected where possible
//   dec_class out   : clean / corrected / uncorrectable
module hamming84_decode
  import hamming_pkg::*;
(
  input  logic [7:0] codeword,
  output logic [3:0] nibble,
  output dec_class_t dec_class
);

  logic [2:0] syndrome_s;
  logic       parity_s;
  logic [7:0] fixed_s;

  // Syndrome, overall parity, single-bit correction and classification.
  always_comb begin
    syndrome_s[0] = codeword[CW_P1] ^ codeword[CW_D0] ^ codeword[CW_D1] ^ codeword[CW_D3];
    syndrome_s[1] = codeword[CW_P2] ^ codeword[CW_D0] ^ codeword[CW_D2] ^ codeword[CW_D3];
    syndrome_s[2] = codeword[CW_P4] ^ codeword[CW_D1] ^ codeword[CW_D2] ^ codeword[CW_D3];
    parity_s      = parity7(codeword[6:0]) ^ codeword[CW_P8];
    fixed_s       = codeword;
    dec_class     = CLASS_CLEAN;
    if (parity_s) begin
      dec_class = CLASS_CORR;
      // A zero syndrome with odd parity means only the overall parity bit flipped.
      if (syndrome_s != 3'd0) begin
        fixed_s[syndrome_s - 3'd1] = ~codeword[syndrome_s - 3'd1];
      end else begin
        fixed_s = codeword;
      end
    end else if (syndrome_s != 3'd0) begin
      dec_class = CLASS_UNCORR;
    end else begin
      dec_class = CLASS_CLEAN;
    end
    nibble = {fixed_s[CW_D3], fixed_s[CW_D2], fixed_s[CW_D1], fixed_s[CW_D0]};
  end

endmodule

// File: rtl/hamming_byte_decoder.sv
// hamming_byte_decoder: decodes SECDED codewords, pairs nibbles into bytes
// (high nibble first) and presents them on a single-entry valid/ready register.
// Ports:
//   clock, reset (async, active-high)
//   io_in_valid/io_in_data    : codeword strobe and data, no backpressure
//   io_sync                   : drop any held high nibble
//   io_out_valid/ready/data/err : decoded byte handshake, err = uncorrectable nibble
//   io_overflow               : sticky, a formed byte found the output full
//   io_corr_count/io_uncorr_count : saturating per-codeword error statistics
module hamming_byte_decoder
  import hamming_pkg::*;
#(
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  input  logic [7:0]       io_in_data,
  input  logic             io_sync,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [7:0]       io_out_data,
  output logic             io_out_err,
  output logic             io_overflow,
  output logic [CNT_W-1:0] io_corr_count,
  output logic [CNT_W-1:0] io_uncorr_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [3:0]       dec_nibble_s;
  dec_class_t       dec_class_s;
  logic             s1_valid_r;
  logic [3:0]       s1_nibble_r;
  logic             s1_corr_r;
  logic             s1_uncorr_r;
  pair_state_t      state_r;
  pair_state_t      state_next_s;
  logic [3:0]       hi_nibble_r;
  logic [3:0]       hi_nibble_next_s;
  logic             hi_err_r;
  logic             hi_err_next_s;
  logic             form_s;
  logic [7:0]       byte_s;
  logic             byte_err_s;
  logic             out_valid_r;
  logic [7:0]       out_data_r;
  logic             out_err_r;
  logic             overflow_r;
  logic [CNT_W-1:0] corr_cnt_r;
  logic [CNT_W-1:0] uncorr_cnt_r;

  hamming84_decode u_decode (
    .codeword  (io_in_data),
    .nibble    (dec_nibble_s),
    .dec_class (dec_class_s)
  );

  // Stage 1: register the decoded nibble and its class flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid_r  <= 1'b0;
      s1_nibble_r <= 4'h0;
      s1_corr_r   <= 1'b0;
      s1_uncorr_r <= 1'b0;
    end else begin
      s1_valid_r <= io_in_valid;
      if (io_in_valid) begin
        s1_nibble_r <= dec_nibble_s;
        s1_corr_r   <= (dec_class_s == CLASS_CORR);
        s1_uncorr_r <= (dec_class_s == CLASS_UNCORR);
      end
    end
  end

  // Pairing FSM state and held high nibble.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= WAIT_HI;
      hi_nibble_r <= 4'h0;
      hi_err_r    <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      hi_nibble_r <= hi_nibble_next_s;
      hi_err_r    <= hi_err_next_s;
    end
  end

  // Pairing next-state; resync wins over a simultaneous stage-1 nibble.
  always_comb begin
    state_next_s     = state_r;
    hi_nibble_next_s = hi_nibble_r;
    hi_err_next_s    = hi_err_r;
    form_s           = 1'b0;
    byte_s           = 8'h00;
    byte_err_s       = 1'b0;
    if (io_sync) begin
      state_next_s     = WAIT_HI;
      hi_nibble_next_s = 4'h0;
      hi_err_next_s    = 1'b0;
    end else if (s1_valid_r) begin
      case (state_r)
        WAIT_HI: begin
          hi_nibble_next_s = s1_nibble_r;
          hi_err_next_s    = s1_uncorr_r;
          state_next_s     = WAIT_LO;
        end
        WAIT_LO: begin
          form_s       = 1'b1;
          byte_s       = {hi_nibble_r, s1_nibble_r};
          byte_err_s   = hi_err_r | s1_uncorr_r;
          state_next_s = WAIT_HI;
        end
        default: begin
          state_next_s = WAIT_HI;
        end
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Single-entry output register; a byte that finds it full is dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      out_data_r  <= 8'h00;
      out_err_r   <= 1'b0;
      overflow_r  <= 1'b0;
    end else if (form_s) begin
      if (!out_valid_r || io_out_ready) begin
        out_valid_r <= 1'b1;
        out_data_r  <= byte_s;
        out_err_r   <= byte_err_s;
      end else begin
        overflow_r <= 1'b1;
      end
    end else if (io_out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  // Saturating per-codeword error statistics.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      corr_cnt_r   <= {CNT_W{1'b0}};
      uncorr_cnt_r <= {CNT_W{1'b0}};
    end else if (s1_valid_r) begin
      if (s1_corr_r && (corr_cnt_r != CNT_MAX)) begin
        corr_cnt_r <= corr_cnt_r + CNT_W'(1);
      end
      if (s1_uncorr_r && (uncorr_cnt_r != CNT_MAX)) begin
        uncorr_cnt_r <= uncorr_cnt_r + CNT_W'(1);
      end
    end
  end

  assign io_out_valid    = out_valid_r;
  assign io_out_data     = out_data_r;
  assign io_out_err      = out_err_r;
  assign io_overflow     = overflow_r;
  assign io_corr_count   = corr_cnt_r;
  assign io_uncorr_count = uncorr_cnt_r;

endmodule

// File: tb/tb_hamming_byte_decoder.sv
// tb_hamming_byte_decoder: scenario tasks with a queue scoreboard of expected
// {err, byte} values. Counters use a 2-bit width so saturation is reachable.
module tb_hamming_byte_decoder;

  localparam int unsigned TB_CNT_W = 2;

  logic                clock = 1'b0;
  logic                reset;
  logic                io_in_valid;
  logic [7:0]          io_in_data;
  logic                io_sync;
  logic                io_out_valid;
  logic                io_out_ready;
  logic [7:0]          io_out_data;
  logic                io_out_err;
  logic                io_overflow;
  logic [TB_CNT_W-1:0] io_corr_count;
  logic [TB_CNT_W-1:0] io_uncorr_count;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] sb[$];

  hamming_byte_decoder #(.CNT_W(TB_CNT_W)) dut (
    .clock           (clock),
    .reset           (reset),
    .io_in_valid     (io_in_valid),
    .io_in_data      (io_in_data),
    .io_sync         (io_sync),
    .io_out_valid    (io_out_valid),
    .io_out_ready    (io_out_ready),
    .io_out_data     (io_out_data),
    .io_out_err      (io_out_err),
    .io_overflow     (io_overflow),
    .io_corr_count   (io_corr_count),
    .io_uncorr_count (io_uncorr_count)
  );

  always #5 clock = ~clock;

  // Drive one codeword for exactly one rising edge; call at a falling edge.
  task automatic send_cw(input logic [7:0] cw);
    io_in_valid = 1'b1;
    io_in_data  = cw;
    @(negedge clock);
    io_in_valid = 1'b0;
    io_in_data  = 8'h00;
  endtask

  // Wait (bounded) until io_out_valid is seen at a falling edge.
  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (io_out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset;
    reset        = 1'b1;
    io_in_valid  = 1'b0;
    io_in_data   = 8'h00;
    io_sync      = 1'b0;
    io_out_ready = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({io_out_valid, io_out_err, io_overflow} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: valid/err/ovf got %b expected 000", {io_out_valid, io_out_err, io_overflow});
    end
    checks++;
    if (io_out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got %h expected 00", io_out_data);
    end
    checks++;
    if ({io_corr_count, io_uncorr_count} !== 4'h0) begin
      errors++;
      $display("FAIL reset_counts: got %0d/%0d expected 0/0", io_corr_count, io_uncorr_count);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_clean;
    bit ok;
    @(negedge clock);
    sb.push_back({1'b0, 8'hA5});
    send_cw(8'hD2);
    send_cw(8'h2D);
    checks++;
    if (io_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clean_latency_early: valid got %b expected 0", io_out_valid);
    end
    @(negedge clock);
    checks++;
    if (io_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL clean_latency: valid got %b expected 1", io_out_valid);
    end
    wait_valid(8, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL clean_timeout: valid got %b expected 1", io_out_valid);
    end else if (sb.size() == 0) begin
      errors++;
      $display("FAIL clean_sb: got empty queue expected one entry");
    end else begin
      logic [8:0] exp;
      exp = sb.pop_front();
      if ({io_out_err, io_out_data} !== exp) begin
        errors++;
        $display("FAIL clean_byte: got %h expected %h", {io_out_err, io_out_data}, exp);
      end
    end
    checks++;
    if ({io_corr_count, io_uncorr_count} !== 4'h0) begin
      errors++;
      $display("FAIL clean_counts: got %0d/%0d expected 0/0", io_corr_count, io_uncorr_count);
    end
    @(negedge clock);
    checks++;
    if (io_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clean_accept: valid got %b expected 0", io_out_valid);
    end
  endtask

  task automatic test_single;
    bit         ok;
    logic [7:0] first_cw[2];
    first_cw[0] = 8'hC2;
    first_cw[1] = 8'h52;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      sb.push_back({1'b0, 8'hA5});
      send_cw(first_cw[k]);
      send_cw(8'h2D);
      wait_valid(8, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL single_timeout_%0d: valid got %b expected 1", k, io_out_valid);
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL single_sb_%0d: got empty queue expected one entry", k);
      end else begin
        logic [8:0] exp;
        exp = sb.pop_front();
        if ({io_out_err, io_out_data} !== exp) begin
          errors++;
          $display("FAIL single_byte_%0d: got %h expected %h", k, {io_out_err, io_out_data}, exp);
        end
      end
      checks++;
      if (io_corr_count !== TB_CNT_W'(k + 1) || io_uncorr_count !== 2'd0) begin
        errors++;
        $display("FAIL single_counts_%0d: got %0d/%0d expected %0d/0", k, io_corr_count, io_uncorr_count, k + 1);
      end
    end
  endtask

  task automatic test_double;
    bit ok;
    @(negedge clock);
    sb.push_back({1'b1, 8'hA5});
    send_cw(8'hD2);
    send_cw(8'h2E);
    wait_valid(8, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL double_timeout: valid got %b expected 1", io_out_valid);
    end else if (sb.size() == 0) begin
      errors++;
      $display("FAIL double_sb: got empty queue expected one entry");
    end else begin
      logic [8:0] exp;
      exp = sb.pop_front();
      if ({io_out_err, io_out_data} !== exp) begin
        errors++;
        $display("FAIL double_byte: got %h expected %h", {io_out_err, io_out_data}, exp);
      end
    end
    checks++;
    if (io_corr_count !== 2'd2 || io_uncorr_count !== 2'd1) begin
      errors++;
      $display("FAIL double_counts: got %0d/%0d expected 2/1", io_corr_count, io_uncorr_count);
    end
  endtask

  task automatic test_saturate;
    bit ok;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      sb.push_back({1'b0, 8'hA5});
      send_cw(8'hC2);
      send_cw(8'h2D);
      wait_valid(8, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL sat_timeout_%0d: valid got %b expected 1", k, io_out_valid);
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL sat_sb_%0d: got empty queue expected one entry", k);
      end else begin
        logic [8:0] exp;
        exp = sb.pop_front();
        if ({io_out_err, io_out_data} !== exp) begin
          errors++;
          $display("FAIL sat_byte_%0d: got %h expected %h", k, {io_out_err, io_out_data}, exp);
        end
      end
      checks++;
      if (io_corr_count !== 2'd3 || io_uncorr_count !== 2'd1) begin
        errors++;
        $display("FAIL sat_counts_%0d: got %0d/%0d expected 3/1", k, io_corr_count, io_uncorr_count);
      end
    end
  endtask

  task automatic test_backpressure;
    @(negedge clock);
    io_out_ready = 1'b0;
    sb.push_back({1'b0, 8'hA5});
    send_cw(8'hD2);
    send_cw(8'h2D);
    send_cw(8'h2D);
    send_cw(8'hD2);
    checks++;
    if (io_out_valid !== 1'b1 || io_overflow !== 1'b0) begin
      errors++;
      $display("FAIL bp_before_drop: valid/ovf got %b%b expected 10", io_out_valid, io_overflow);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (io_overflow !== 1'b1) begin
      errors++;
      $display("FAIL bp_overflow: got %b expected 1", io_overflow);
    end
    checks++;
    if (io_out_valid !== 1'b1 || {io_out_err, io_out_data} !== sb[0]) begin
      errors++;
      $display("FAIL bp_hold: valid=%b data got %h expected %h", io_out_valid, {io_out_err, io_out_data}, sb[0]);
    end
    io_out_ready = 1'b1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL bp_sb: got empty queue expected one entry");
    end else begin
      logic [8:0] exp;
      exp = sb.pop_front();
      if ({io_out_err, io_out_data} !== exp) begin
        errors++;
        $display("FAIL bp_byte: got %h expected %h", {io_out_err, io_out_data}, exp);
      end
    end
    @(negedge clock);
    checks++;
    if (io_out_valid !== 1'b0 || io_overflow !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept: valid/ovf got %b%b expected 01", io_out_valid, io_overflow);
    end
  endtask

  task automatic test_resync;
    bit ok;
    @(negedge clock);
    send_cw(8'hD2);
    io_sync = 1'b1;
    @(negedge clock);
    io_sync = 1'b0;
    sb.push_back({1'b0, 8'h5A});
    send_cw(8'h2D);
    send_cw(8'hD2);
    wait_valid(8, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL resync_timeout: valid got %b expected 1", io_out_valid);
    end else if (sb.size() == 0) begin
      errors++;
      $display("FAIL resync_sb: got empty queue expected one entry");
    end else begin
      logic [8:0] exp;
      exp = sb.pop_front();
      if ({io_out_err, io_out_data} !== exp) begin
        errors++;
        $display("FAIL resync_byte: got %h expected %h", {io_out_err, io_out_data}, exp);
      end
    end
    repeat (3) @(negedge clock);
    checks++;
    if (io_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL resync_extra: valid got %b expected 0", io_out_valid);
    end
  endtask

  task automatic test_reset_midbyte;
    bit ok;
    @(negedge clock);
    send_cw(8'hD2);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({io_out_valid, io_out_err, io_overflow} !== 3'b000 || io_out_data !== 8'h00) begin
      errors++;
      $display("FAIL midreset_out: v/e/o=%b data=%h expected 000 00", {io_out_valid, io_out_err, io_overflow}, io_out_data);
    end
    checks++;
    if ({io_corr_count, io_uncorr_count} !== 4'h0) begin
      errors++;
      $display("FAIL midreset_counts: got %0d/%0d expected 0/0", io_corr_count, io_uncorr_count);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    sb.push_back({1'b0, 8'h5A});
    send_cw(8'h2D);
    send_cw(8'hD2);
    wait_valid(8, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL midreset_timeout: valid got %b expected 1", io_out_valid);
    end else if (sb.size() == 0) begin
      errors++;
      $display("FAIL midreset_sb: got empty queue expected one entry");
    end else begin
      logic [8:0] exp;
      exp = sb.pop_front();
      if ({io_out_err, io_out_data} !== exp) begin
        errors++;
        $display("FAIL midreset_byte: got %h expected %h", {io_out_err, io_out_data}, exp);
      end
    end
    checks++;
    if ({io_corr_count, io_uncorr_count} !== 4'h0 || io_overflow !== 1'b0) begin
      errors++;
      $display("FAIL midreset_after: counts %0d/%0d ovf %b expected 0/0 0", io_corr_count, io_uncorr_count, io_overflow);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single();
    test_double();
    test_saturate();
    test_backpressure();
    test_resync();
    test_reset_midbyte();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hamming_byte_decoder.md
# hamming_byte_decoder

Consumes the 8-bit codewords produced by the serial code receiver and decodes each as extended Hamming(8,4) SECDED. Corrects single-bit errors and flags double-bit errors. Pairs consecutive decoded nibbles into bytes, high nibble first, and presents them on a valid/ready output register. Sits between the receive-side deserializer and the byte sink, and keeps saturating error statistics.

## Interface
- `CNT_W`, default 16: width of the error statistic counters.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high. Clears all state.
- `io_in_valid` in 1: single-cycle strobe. `io_in_data` holds a new codeword.
- `io_in_data` in 8: codeword, sampled when `io_in_valid` is 1.
- `io_sync` in 1: frame resync pulse. Discards any held high nibble.
- `io_out_valid` out 1: output byte available.
- `io_out_ready` in 1: sink accepts the byte when it is high together with `io_out_valid`.
- `io_out_data` out 8: decoded byte.
- `io_out_err` out 1: at least one nibble of `io_out_data` was uncorrectable.
- `io_overflow` out 1: sticky. A completed byte was dropped.
- `io_corr_count` out CNT_W: count of corrected codewords, saturating.
- `io_uncorr_count` out CNT_W: count of uncorrectable codewords, saturating.

## Operation
- Codeword layout, bit i = Hamming position i+1:
  - b0 = p1, b1 = p2, b2 = d0, b3 = p4, b4 = d1, b5 = d2, b6 = d3.
  - b7 = even parity over b6..b0.
- Syndrome bits:
  - s1 = b0^b2^b4^b6
  - s2 = b1^b2^b5^b6
  - s4 = b3^b4^b5^b6
  - S = {s4,s2,s1}; P = XOR of all 8 bits.
- Decode classes:
  - S=0, P=0: clean.
  - P=1: single error. If S≠0, flip bit S-1. If S=0, the error is in b7 and data is unaffected. Counts as corrected.
  - S≠0, P=0: double error. Data passes uncorrected, flagged uncorrectable.
- Stage 1 is a registered decode of the accepted codeword: nibble {d3,d2,d1,d0}, plus corr and uncorr flags, plus a valid bit.
- Pairing FSM, states WAIT_HI and WAIT_LO; reset state is WAIT_HI.
  - WAIT_HI + stage-1 valid: store the nibble as the high nibble and its uncorr flag, go to WAIT_LO.
  - WAIT_LO + stage-1 valid: form byte = {hi, lo} and err = hi_err | lo_err, go to WAIT_HI.
  - `io_sync`=1: go to WAIT_HI and clear the held nibble. This has priority over stage-1 valid in the same cycle; that nibble is discarded.
- Output register, single entry:
  - Loads when a byte forms and either `io_out_valid`=0 or `io_out_ready`=1 in the same cycle.
  - If a byte forms while `io_out_valid`=1 and `io_out_ready`=0: the new byte is dropped, `io_overflow` is set, and the output register holds.
  - Accept and form in the same cycle: the new byte is loaded and `io_out_valid` stays 1.
  - Accept without form: `io_out_valid` goes to 0.
  - `io_out_data` and `io_out_err` are stable while `io_out_valid`=1 and `io_out_ready`=0.
- Counters: `io_corr_count` and `io_uncorr_count` increment by 1 per stage-1 valid codeword of the matching class. They saturate at all-ones. They are not affected by `io_sync` or overflow.
- `io_overflow` clears only on reset.

## Timing
- Reset values: `io_out_valid`=0, `io_out_data`=0x00, `io_out_err`=0, `io_overflow`=0, both counters 0, FSM=WAIT_HI, stage-1 valid=0.
- Codeword sampled at edge E → stage 1 updates at E. FSM, output register and counters update at E+1.
- `io_out_valid` rises after edge E+1, where E is the sampling edge of the low codeword. Latency is 2 edges.
- The block accepts back-to-back `io_in_valid` every cycle. There is no input backpressure.
- Reset asserted mid-byte: the held nibble, stage 1 and the output register are discarded immediately, independent of the clock.

## Structure
- `hamming_pkg`:
  - FSM state enum {WAIT_HI, WAIT_LO}.
  - Codeword bit-position constants.
  - Decode-class encoding.
  - Default CNT_W.
- Sub-module `hamming84_decode`: combinational syndrome, correction and classification. It is instantiated once, feeding the stage-1 registers.
- Top level: stage 1, pairing FSM, output register, counters and overflow logic.

## Test plan
- Clean byte: codewords 0xD2 then 0x2D → `io_out_data`=0xA5, `io_out_err`=0, both counters 0, `io_out_valid` high 2 edges after the second codeword.
- Single error: 0xC2 (bit 4 flipped) then 0x2D → 0xA5, `io_corr_count`=1. Also 0x52 (b7 flipped) then 0x2D → 0xA5, `io_corr_count`=2.
- Double error: 0xD2 then 0x2E → `io_out_err`=1, `io_uncorr_count`=1, low nibble = raw data bits of 0x2E.
- Backpressure: hold `io_out_ready`=0 while sending two clean bytes → first byte held stable, second dropped, `io_overflow`=1. Then ready=1 → first byte accepted, `io_out_valid`=0.
- Resync: 0xD2, then `io_sync` pulse, then 0x2D, 0xD2 → output byte 0x5A; no byte is formed from the discarded 0xD2.
- Reset mid-byte: 0xD2, then reset asserted asynchronously → all outputs at reset values, and the next two codewords form a fresh byte.
